// File: rtl/sprite_arb_pkg.sv
// Shared defaults, state encoding and width helper for the sprite ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_arb_pkg;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 3;
   localparam int DEF_LEN_W  = 6;

   // Index width for a requester count; a single requester still gets one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_ID_W = id_width(DEF_N_REQ);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sprite_arb_pick.sv
// Winner select: first asserted req found scanning upward from ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; a pointer of zero gives plain lowest-index priority.
module sprite_arb_pick
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = id_width(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [N_REQ-1:0] onehot,
   output logic [ID_W-1:0]  idx
);

   logic [ID_W-1:0] cand;

   // Rotating scan: the first candidate at or after ptr that is requesting wins.
   always_comb begin
      any    = 1'b0;
      onehot = '0;
      idx    = '0;
      cand   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ID_W'((int'(ptr) + i) % N_REQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            onehot[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Burst arbiter sharing one synchronous sprite ROM between sprite engines (RR order if SPRITE_ARB_RR_EN).
// Latency: gnt and first address one cycle after selection; each word returns one cycle after its address.
// Backpressure: none; losers keep req high and are picked at the winner's final issue cycle.
module sprite_rom_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int ID_W   = id_width(N_REQ)
)(
   input  logic                    vga_clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*LEN_W-1:0]  req_len,
   output logic [N_REQ-1:0]        gnt,
   output logic                    busy,
   output logic [ADDR_W-1:0]       rom_address,
   input  logic [DATA_W-1:0]       rom_q,
   output logic                    rd_valid,
   output logic [ID_W-1:0]         rd_id,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_last
);

   arb_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  cnt_q;
   logic [ID_W-1:0]   owner_q;
   logic [N_REQ-1:0]  gnt_q;
   logic              rd_valid_q;
   logic [ID_W-1:0]   rd_id_q;
   logic              rd_last_q;

   logic              pick_any;
   logic [N_REQ-1:0]  pick_onehot;
   logic [ID_W-1:0]   pick_idx;
   logic [ID_W-1:0]   pick_ptr;
   logic              last_issue;
   logic              sel_en;
   logic [LEN_W-1:0]  sel_len;
   logic [LEN_W-1:0]  load_len;

   logic [ADDR_W-1:0] addr_arr [N_REQ];
   logic [LEN_W-1:0]  len_arr  [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
      assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
   end

   sprite_arb_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .any    (pick_any),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

`ifdef SPRITE_ARB_RR_EN
   logic [ID_W-1:0] ptr_q;

   // Search for the next winner starts just past the most recent grant.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (sel_en) begin
         ptr_q <= (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
      end
   end

   assign pick_ptr = ptr_q;
`else
   assign pick_ptr = '0;
`endif

   // A zero length still fetches one word.
   assign sel_len    = len_arr[pick_idx];
   assign load_len   = (sel_len == '0) ? LEN_W'(1) : sel_len;
   assign last_issue = (state_q == ST_BURST) && (cnt_q == LEN_W'(1));
   assign sel_en     = ((state_q == ST_IDLE) || last_issue) && pick_any;

   // State register.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: chain straight into another burst when someone is waiting.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) state_d = ST_BURST;
         end
         ST_BURST: begin
            if (last_issue) state_d = pick_any ? ST_BURST : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      busy = (state_q == ST_BURST);
   end

   // Burst datapath: latch the winner's request, then walk the address down the count.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         cnt_q   <= '0;
         owner_q <= '0;
         gnt_q   <= '0;
      end else if (sel_en) begin
         addr_q  <= addr_arr[pick_idx];
         cnt_q   <= load_len;
         owner_q <= pick_idx;
         gnt_q   <= pick_onehot;
      end else begin
         gnt_q <= '0;
         if ((state_q == ST_BURST) && !last_issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q - LEN_W'(1);
         end
      end
   end

   // Return tags line up with rom_q, which lags the issued address by one cycle.
   always_ff @(posedge vga_clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_id_q    <= '0;
         rd_last_q  <= 1'b0;
      end else begin
         rd_valid_q <= (state_q == ST_BURST);
         rd_id_q    <= owner_q;
         rd_last_q  <= last_issue;
      end
   end

   assign gnt         = gnt_q;
   assign rom_address = addr_q;
   assign rd_valid    = rd_valid_q;
   assign rd_id       = rd_id_q;
   assign rd_last     = rd_last_q;
   assign rd_data     = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed bursts, scoreboard queues checked by a negedge monitor.
// Latency: models the ROM as one-cycle synchronous read.
// Backpressure: none; requesters drop req after their grant unless held.
module tb_sprite_rom_arbiter;

   logic        vga_clk;
   logic        rst;
   logic [3:0]  req;
   logic [39:0] req_addr;
   logic [23:0] req_len;
   logic [3:0]  gnt;
   logic        busy;
   logic [9:0]  rom_address;
   logic [2:0]  rom_q;
   logic        rd_valid;
   logic [1:0]  rd_id;
   logic [2:0]  rd_data;
   logic        rd_last;

   sprite_rom_arbiter dut (
      .vga_clk     (vga_clk),
      .rst         (rst),
      .req         (req),
      .req_addr    (req_addr),
      .req_len     (req_len),
      .gnt         (gnt),
      .busy        (busy),
      .rom_address (rom_address),
      .rom_q       (rom_q),
      .rd_valid    (rd_valid),
      .rd_id       (rd_id),
      .rd_data     (rd_data),
      .rd_last     (rd_last)
   );

   typedef struct {
      logic [9:0] addr;
      int         id;
      bit         first;
   } iss_t;

   typedef struct {
      int         id;
      logic [2:0] data;
      bit         last;
   } ret_t;

   iss_t iq[$];
   ret_t rq[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [2:0] rom_fn(input logic [9:0] a);
      return a[2:0] ^ a[5:3] ^ a[8:6];
   endfunction

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endfunction

   initial begin
      vga_clk = 1'b0;
      forever #5 vga_clk = ~vga_clk;
   end

   // Synchronous ROM model: word for the address present at an edge appears just after it.
   initial begin
      logic [9:0] a;
      rom_q = '0;
      forever begin
         @(negedge vga_clk);
         a = rom_address;
         @(posedge vga_clk);
         #1 rom_q = rom_fn(a);
      end
   end

   // Expected burst: issue entries and return entries for every word.
   task automatic exp_burst(input int id, input logic [9:0] base, input int len);
      int   n;
      iss_t e;
      ret_t r;
      n = (len == 0) ? 1 : len;
      for (int k = 0; k < n; k++) begin
         e.addr  = base + 10'(k);
         e.id    = id;
         e.first = (k == 0);
         iq.push_back(e);
         r.id   = id;
         r.data = rom_fn(e.addr);
         r.last = (k == n - 1);
         rq.push_back(r);
      end
   endtask

   task automatic set_req(input int i, input logic [9:0] addr, input logic [5:0] len);
      req_addr[i*10 +: 10] = addr;
      req_len[i*6 +: 6]    = len;
   endtask

   // Monitor: every busy cycle must match the next expected issue, every rd_valid the next return.
   iss_t m_e;
   ret_t m_r;
   always @(negedge vga_clk) begin
      if (!rst) begin
         if (busy) begin
            if (iq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: rom_address=0x%0h gnt=%b with nothing expected", rom_address, gnt);
            end else begin
               m_e = iq.pop_front();
               chk("rom_address", int'(rom_address), int'(m_e.addr));
               chk("gnt", int'(gnt), m_e.first ? (1 << m_e.id) : 0);
            end
         end else if (gnt != 4'b0) begin
            chk("gnt_while_idle", int'(gnt), 0);
         end
         if (rd_valid) begin
            if (rq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rd_valid: rd_id=%0d rd_data=%0d with nothing expected", rd_id, rd_data);
            end else begin
               m_r = rq.pop_front();
               chk("rd_id", int'(rd_id), m_r.id);
               chk("rd_data", int'(rd_data), int'(m_r.data));
               chk("rd_last", int'(rd_last), int'(m_r.last));
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      rst = 1'b0;
   endtask

   // Raise requests, drop each after its grant unless held, release all after n_grants.
   task automatic run_burst(input logic [3:0] raise, input logic [3:0] hold_in, input int n_grants,
                            input string tag, output int busy_cycles, output int span);
      logic [3:0] hold;
      int grants, cyc, first, last;
      hold        = hold_in;
      grants      = 0;
      cyc         = 0;
      first       = -1;
      last        = -1;
      busy_cycles = 0;
      req         = req | raise;
      while (cyc < 400) begin
         @(posedge vga_clk);
         #1;
         cyc++;
         if (gnt != 4'b0) begin
            grants++;
            req = req & ~(gnt & ~hold);
            if (grants >= n_grants) begin
               req  = '0;
               hold = '0;
            end
         end
         if (busy) begin
            busy_cycles++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (grants >= n_grants && !busy && !rd_valid && iq.size() == 0 && rq.size() == 0) break;
      end
      span = (first < 0) ? 0 : last - first + 1;
      chk({tag, "_grants"}, grants, n_grants);
      chk({tag, "_issues_left"}, iq.size(), 0);
      chk({tag, "_returns_left"}, rq.size(), 0);
   endtask

   initial begin
      int bc, sp, cyc;
      rst      = 1'b1;
      req      = '0;
      req_addr = '0;
      req_len  = '0;
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_rom_address", int'(rom_address), 0);
      do_reset();
      chk("idle_gnt", int'(gnt), 0);
      chk("idle_rd_valid", int'(rd_valid), 0);

      // Single burst from requester 1.
      set_req(1, 10'h040, 6'd4);
      exp_burst(1, 10'h040, 4);
      run_burst(4'b0010, 4'b0000, 1, "single", bc, sp);
      chk("single_busy_cycles", bc, 4);

      // Two simultaneous requesters: 0 first, then 2 with no idle gap (both builds).
      do_reset();
      set_req(0, 10'h010, 6'd2);
      set_req(2, 10'h200, 6'd2);
      exp_burst(0, 10'h010, 2);
      exp_burst(2, 10'h200, 2);
      run_burst(4'b0101, 4'b0000, 2, "pair", bc, sp);
      chk("pair_busy_cycles", bc, 4);
      chk("pair_no_gap", sp, 4);

      // Requesters 0 and 3 held high across four grants.
      do_reset();
      set_req(0, 10'h100, 6'd2);
      set_req(3, 10'h2A0, 6'd2);
`ifdef SPRITE_ARB_RR_EN
      exp_burst(0, 10'h100, 2);
      exp_burst(3, 10'h2A0, 2);
      exp_burst(0, 10'h100, 2);
      exp_burst(3, 10'h2A0, 2);
`else
      for (int k = 0; k < 4; k++) exp_burst(0, 10'h100, 2);
`endif
      run_burst(4'b1001, 4'b1001, 4, "held", bc, sp);
      chk("held_no_gap", sp, 8);

      // Address wrap at the top of the ROM.
      set_req(2, 10'h3FE, 6'd4);
      exp_burst(2, 10'h3FE, 4);
      run_burst(4'b0100, 4'b0000, 1, "wrap", bc, sp);
      chk("wrap_rom_address_after", int'(rom_address), 1);

      // Zero length fetches exactly one word.
      set_req(3, 10'h155, 6'd0);
      exp_burst(3, 10'h155, 0);
      run_burst(4'b1000, 4'b0000, 1, "len0", bc, sp);
      chk("len0_busy_cycles", bc, 1);

      // Reset during the third word of an eight-word burst from requester 2.
      set_req(2, 10'h080, 6'd8);
      for (int k = 0; k < 3; k++) begin
         m_e.addr  = 10'h080 + 10'(k);
         m_e.id    = 2;
         m_e.first = (k == 0);
         iq.push_back(m_e);
      end
      for (int k = 0; k < 2; k++) begin
         m_r.id   = 2;
         m_r.data = rom_fn(10'h080 + 10'(k));
         m_r.last = 1'b0;
         rq.push_back(m_r);
      end
      req[2] = 1'b1;
      cyc = 0;
      while (cyc < 50 && !(busy && rom_address == 10'h082)) begin
         @(posedge vga_clk);
         #1;
         cyc++;
         if (gnt[2]) req[2] = 1'b0;
      end
      chk("abort_reached_third_word", int'(rom_address), 10'h082);
      @(negedge vga_clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_gnt", int'(gnt), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_rd_valid", int'(rd_valid), 0);
      chk("abort_rd_last", int'(rd_last), 0);
      chk("abort_rd_id", int'(rd_id), 0);
      chk("abort_rom_address", int'(rom_address), 0);
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      rst = 1'b0;
      repeat (5) @(posedge vga_clk);
      #1;
      chk("abort_issues_left", iq.size(), 0);
      chk("abort_returns_left", rq.size(), 0);
      chk("abort_stays_idle", int'(busy), 0);

      // Normal service after the aborted burst.
      set_req(1, 10'h0F0, 6'd3);
      exp_burst(1, 10'h0F0, 3);
      run_burst(4'b0010, 4'b0000, 1, "after_abort", bc, sp);
      chk("after_abort_busy_cycles", bc, 3);

      repeat (3) @(posedge vga_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (player, enemy, item, HUD sprite engines).
REQ-002 Parameter ADDR_W, default 10, sprite ROM address width.
REQ-003 Parameter DATA_W, default 3, palette-index width of ROM word.
REQ-004 Parameter LEN_W, default 6, burst-length field width.
REQ-005 vga_clk  in  1  sole clock; all state changes on rising edge.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  N_REQ  per-requester burst request, level.
REQ-008 req_addr  in  N_REQ*ADDR_W  per-requester burst base address, packed, requester i at slice i.
REQ-009 req_len  in  N_REQ*LEN_W  per-requester word count, packed.
REQ-010 gnt  out  N_REQ  one-hot, one-cycle pulse when burst accepted.
REQ-011 busy  out  1  high while a burst is issuing.
REQ-012 rom_address  out  ADDR_W  address to shared synchronous sprite ROM.
REQ-013 rom_q  in  DATA_W  ROM data, valid one cycle after address.
REQ-014 rd_valid  out  1  rd_data carries a returned word.
REQ-015 rd_id  out  clog2(N_REQ)  owner of returned word.
REQ-016 rd_data  out  DATA_W  returned word, equal to rom_q.
REQ-017 rd_last  out  1  final word of burst.

Function
REQ-018 States IDLE, BURST; reset state IDLE.
REQ-019 IDLE with any req bit high: winner chosen, base and length latched, next state BURST.
REQ-020 First BURST cycle: gnt[winner]=1, rom_address=base; gnt 0 in all other cycles.
REQ-021 Each BURST cycle issues one address; rom_address increments by 1, wraps modulo 2^ADDR_W.
REQ-022 req_len=0 treated as 1; maximum burst 2^LEN_W-1 words.
REQ-023 rd_valid, rd_id, rd_last registered, asserted the cycle after each issue; rd_data=rom_q combinationally.
REQ-024 rd_last high only with final word of burst.
REQ-025 On last issue cycle with another req pending: next state BURST for new winner (no idle gap); else IDLE.
REQ-026 Requester drops req after gnt; req still high at its burst's final issue cycle counts as a new request.
REQ-027 busy=1 exactly in BURST.
REQ-028 rom_address holds last value in IDLE.
REQ-029 req, req_addr, req_len sampled only at winner selection; changes during burst ignored.

Reset
REQ-030 Reset asserted: state IDLE, gnt=0, busy=0, rd_valid=0, rd_last=0, rd_id=0, rom_address=0, priority pointer 0, immediately, including mid-burst; aborted burst words not returned.
REQ-031 First selection possible on first rising edge after Reset deasserts.

Configuration
REQ-032 Macro SPRITE_ARB_RR_EN defined: round-robin; search starts at pointer, pointer set to winner+1 mod N_REQ at each grant.
REQ-033 SPRITE_ARB_RR_EN undefined: fixed priority, lowest index wins, no pointer register.

Structure
REQ-034 Package sprite_arb_pkg holds N_REQ, ADDR_W, DATA_W, LEN_W, ID_W defaults and state enum.
REQ-035 Sub-module sprite_arb_pick: combinational winner select from req and pointer, one-hot plus index output.

Verification
REQ-036 Single req[1], addr 0x040, len 4 -> gnt[1] one pulse, rom_address 0x040..0x043, four rd_valid with rd_id=1, rd_last on fourth.
REQ-037 req[0], req[2] simultaneous, len 2 each, RR build -> req0 granted first, req2 next with no idle cycle; fixed build same order.
REQ-038 RR build, req[0] held high continuously, req[3] high -> grants alternate 0,3,0,3; fixed build -> req[0] only.
REQ-039 addr 0x3FE, len 4 -> rom_address 0x3FE,0x3FF,0x000,0x001.
REQ-040 req_len=0 -> exactly one word, rd_last with it.
REQ-041 Reset at third word of 8-word burst -> all outputs reset values same cycle, no further rd_valid, next request granted normally.
